// File: rtl/ccc_cfg_pkg.sv
// ccc_cfg_pkg
// Shared definitions for the MSS CCC dynamic-configuration sequencer:
// sequencer state encoding, configuration word width and the bit-field
// layout of the configuration word. Firmware builds its words from the
// same offsets, so both sides produce identical bit patterns.
package ccc_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_UPDATE    = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } ccc_state_e;

    localparam int CCC_CFG_W = 81;

    // Configuration word fields (LSB position, width). Bits above 40 are reserved.
    localparam int CCC_FINDIV_LSB   = 0;
    localparam int CCC_FINDIV_W     = 7;
    localparam int CCC_FBDIV_LSB    = 7;
    localparam int CCC_FBDIV_W      = 7;
    localparam int CCC_OADIV_LSB    = 14;
    localparam int CCC_OADIV_W      = 5;
    localparam int CCC_OBDIV_LSB    = 19;
    localparam int CCC_OBDIV_W      = 5;
    localparam int CCC_OCDIV_LSB    = 24;
    localparam int CCC_OCDIV_W      = 5;
    localparam int CCC_OAMUX_LSB    = 29;
    localparam int CCC_OAMUX_W      = 3;
    localparam int CCC_OBMUX_LSB    = 32;
    localparam int CCC_OBMUX_W      = 3;
    localparam int CCC_OCMUX_LSB    = 35;
    localparam int CCC_OCMUX_W      = 3;
    localparam int CCC_BYPASSA_BIT  = 38;
    localparam int CCC_BYPASSB_BIT  = 39;
    localparam int CCC_BYPASSC_BIT  = 40;

endpackage

// File: rtl/ccc_dyncfg_ctrl_if.sv
// ccc_dyncfg_ctrl_if
// Serial dynamic-configuration port between the fabric sequencer (master)
// and the MSS_CCC instance (slave).
//   SCLK    master->slave  configuration shift clock
//   SDIN    master->slave  serial configuration data, MSB first
//   SSHIFT  master->slave  high while shifting
//   SUPDATE master->slave  apply the shifted word
//   LOCK    slave->master  PLL lock, asynchronous to the sequencer clock
interface ccc_dyncfg_ctrl_if;
    logic SCLK;
    logic SDIN;
    logic SSHIFT;
    logic SUPDATE;
    logic LOCK;

    modport master (output SCLK, output SDIN, output SSHIFT, output SUPDATE, input LOCK);
    modport slave  (input SCLK, input SDIN, input SSHIFT, input SUPDATE, output LOCK);
endinterface

// File: rtl/ccc_lock_sync.sv
// ccc_lock_sync
// Brings the CCC LOCK into the PCLK domain and qualifies it.
//   PCLK, PRESERN  clock, async active-low reset
//   LOCK           raw lock from the CCC
//   clr            clear the stable counter
//   en             count enable (sequencer waiting for lock)
//   lock_ok        level: this edge completes LOCK_STABLE consecutive high cycles
//   lock_drop      pulse: synchronized lock just fell
module ccc_lock_sync
    import ccc_cfg_pkg::*;
#(
    parameter int LOCK_STABLE = 16
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic LOCK,
    input  logic clr,
    input  logic en,
    output logic lock_ok,
    output logic lock_drop
);
    localparam int CNT_W = $clog2(LOCK_STABLE) + 1;
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(LOCK_STABLE);

    logic             lock_m;
    logic             lock_s;
    logic             lock_q;
    logic [CNT_W-1:0] stab_cnt;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            lock_m   <= 1'b0;
            lock_s   <= 1'b0;
            lock_q   <= 1'b0;
            stab_cnt <= '0;
        end else begin
            lock_m <= LOCK;
            lock_s <= lock_m;
            lock_q <= lock_s;
            if (clr || !lock_s) begin
                stab_cnt <= '0;
            end else if (en && stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // Qualified on the edge that would bring the count to LOCK_STABLE.
    assign lock_ok   = en && lock_s && (stab_cnt == STAB_LAST);
    assign lock_drop = lock_q && !lock_s;

endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// ccc_dyncfg_ctrl
// Shifts a configuration word into the MSS CCC, strobes update, waits for
// qualified PLL lock and then releases the reset of the CCC-clocked fabric.
//   PCLK, PRESERN  free-running clock, async active-low reset
//   START, CFG     (re)configure request and word, accepted in IDLE/RUN/FAULT
//   ccc            serial configuration port to the CCC (master side)
//   BUSY           configuring or waiting for lock
//   LOCKED         running with qualified lock
//   FAULT          sticky lock timeout / loss of lock
//   FAB_RST_N      active-low fabric reset
//
// state      | meaning
// IDLE       | after reset, nothing applied yet, fabric held in reset
// SHIFT      | clocking the word out on SCLK/SDIN
// UPDATE     | SUPDATE strobe applying the word
// WAIT_LOCK  | waiting for LOCK_STABLE synchronized lock cycles
// RUN        | locked, fabric released
// FAULT      | timeout or lock lost, fabric held until next START
module ccc_dyncfg_ctrl
    import ccc_cfg_pkg::*;
#(
    parameter int CFG_W        = CCC_CFG_W,
    parameter int SCLK_DIV     = 2,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             START,
    input  logic [CFG_W-1:0] CFG,
    ccc_dyncfg_ctrl_if.master ccc,
    output logic             BUSY,
    output logic             LOCKED,
    output logic             FAULT,
    output logic             FAB_RST_N
);
    localparam int BIT_W = $clog2(CFG_W) + 1;
    localparam int DIV_W = $clog2(2 * SCLK_DIV) + 1;
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CFG_W - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] UPD_LAST  = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

    ccc_state_e       state;
    logic [CFG_W-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             sclk;
    logic             sshift;
    logic             supdate;
    logic             stab_clr;
    logic             stab_en;
    logic             lock_ok;
    logic             lock_drop;

    assign stab_clr = (state == ST_UPDATE);
    assign stab_en  = (state == ST_WAIT_LOCK);

    ccc_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
        .PCLK      (PCLK),
        .PRESERN   (PRESERN),
        .LOCK      (ccc.LOCK),
        .clr       (stab_clr),
        .en        (stab_en),
        .lock_ok   (lock_ok),
        .lock_drop (lock_drop)
    );

    // SDIN is the shift register MSB; the register is zeroed when shifting
    // ends, so SDIN is low everywhere outside SHIFT.
    assign ccc.SCLK    = sclk;
    assign ccc.SDIN    = shreg[CFG_W-1];
    assign ccc.SSHIFT  = sshift;
    assign ccc.SUPDATE = supdate;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            tmo_cnt   <= '0;
            sclk      <= 1'b0;
            sshift    <= 1'b0;
            supdate   <= 1'b0;
            BUSY      <= 1'b0;
            LOCKED    <= 1'b0;
            FAULT     <= 1'b0;
            FAB_RST_N <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN, ST_FAULT: begin
                    if (START) begin
                        state     <= ST_SHIFT;
                        shreg     <= CFG;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        sclk      <= 1'b0;
                        sshift    <= 1'b1;
                        BUSY      <= 1'b1;
                        LOCKED    <= 1'b0;
                        FAULT     <= 1'b0;
                        FAB_RST_N <= 1'b0;
                    end else if (state == ST_RUN && lock_drop) begin
                        state     <= ST_FAULT;
                        LOCKED    <= 1'b0;
                        FAULT     <= 1'b1;
                        FAB_RST_N <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // falling edge: next bit, or done after the last high phase
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state   <= ST_UPDATE;
                                shreg   <= '0;
                                sshift  <= 1'b0;
                                supdate <= 1'b1;
                            end else begin
                                shreg   <= {shreg[CFG_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (div_cnt == UPD_LAST) begin
                        state   <= ST_WAIT_LOCK;
                        div_cnt <= '0;
                        tmo_cnt <= '0;
                        supdate <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (lock_ok) begin
                        state     <= ST_RUN;
                        BUSY      <= 1'b0;
                        LOCKED    <= 1'b1;
                        FAB_RST_N <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= ST_FAULT;
                        BUSY  <= 1'b0;
                        FAULT <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ccc_dyncfg_ctrl.md
# ccc_dyncfg_ctrl

Sequencer for the MSS clock conditioning circuit's dynamic configuration port. It serially shifts a configuration word into the CCC, applies it with an update strobe, then waits for PLL lock. Fabric reset is released only after lock has been stable for a qualified interval. It sits in the fabric beside the MSS_CCC instance, on the always-running RC-oscillator-derived clock, and gates the reset of all logic clocked from GLA/GLB/GLC.

## Interface
- CFG_W, 81, configuration word width in bits
- SCLK_DIV, 2, PCLK cycles per SCLK half-period (≥1)
- LOCK_STABLE, 16, consecutive synchronized-LOCK-high cycles required before release (≥1)
- LOCK_TIMEOUT, 1024, PCLK cycles allowed from update to qualified lock

- PCLK  in  1  clock; free-running, independent of the CCC outputs
- PRESERN  in  1  reset, asynchronous, active-low
- START  in  1  single-cycle request to (re)configure; sampled only in IDLE, RUN, FAULT
- CFG  in  CFG_W  configuration word; captured on accepted START
- LOCK  in  1  CCC lock, asynchronous to PCLK
- SCLK  out  1  config shift clock
- SDIN  out  1  config serial data, MSB first
- SSHIFT  out  1  high while shifting
- SUPDATE  out  1  update strobe
- BUSY  out  1  high in SHIFT, UPDATE, WAIT_LOCK
- LOCKED  out  1  high in RUN
- FAULT  out  1  sticky: lock timeout or loss of lock
- FAB_RST_N  out  1  active-low reset to clocked fabric

## Operation
- States: IDLE, SHIFT, UPDATE, WAIT_LOCK, RUN, FAULT.
- Reset values: all outputs 0, including FAB_RST_N (fabric held in reset). State is IDLE. Shift register, bit counter, divider counter, and lock counters are 0.
- LOCK passes through a 2-flop synchronizer (lock_s). Only lock_s is used.
- IDLE/RUN/FAULT, START=1:
  - Capture CFG into the shift register.
  - Go to SHIFT.
  - Drive FAB_RST_N=0 and LOCKED=0 the next cycle.
  - Clear FAULT.
- SHIFT:
  - SSHIFT=1 and SDIN=shreg[CFG_W-1] throughout.
  - Each bit: SCLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - Shift register shifts left at the SCLK falling edge, so SDIN changes only while SCLK is low.
  - After the CFG_W-th high phase, SCLK returns low and the state goes to UPDATE.
- UPDATE:
  - SSHIFT=0 and SDIN=0.
  - SUPDATE=1 for exactly 2·SCLK_DIV cycles; SCLK stays low.
  - Then go to WAIT_LOCK and clear the timeout and stable counters.
- WAIT_LOCK:
  - The stable counter increments while lock_s=1 and clears to 0 when lock_s=0.
  - The timeout counter increments every cycle.
  - Stable counter reaching LOCK_STABLE → RUN.
  - Otherwise, timeout counter reaching LOCK_TIMEOUT → FAULT.
  - If both occur on the same cycle, RUN wins.
- RUN:
  - FAB_RST_N=1 and LOCKED=1.
  - lock_s=0 for any cycle → FAULT, with FAB_RST_N=0 on the next cycle.
- FAULT:
  - FAULT=1 and FAB_RST_N=0.
  - Leaves only on START.
- START outside IDLE/RUN/FAULT is ignored, and CFG is not re-captured.
- PRESERN assertion mid-sequence:
  - All outputs go to reset values immediately, asynchronously.
  - SCLK/SSHIFT drop; the partial word is discarded.
  - The CCC keeps its previous applied configuration because SUPDATE was not issued.

## Timing
- START accepted at edge N → SSHIFT=1 from N+1.
- First SCLK rising edge at N+1+SCLK_DIV.
- SHIFT duration: 2·SCLK_DIV·CFG_W cycles.
- UPDATE duration: 2·SCLK_DIV cycles.
- Minimum START→LOCKED: 1 + 2·SCLK_DIV·(CFG_W+1) + 2 (synchronizer) + LOCK_STABLE cycles.
- Counter widths: $clog2 of each bound plus 1; no wrap occurs because the counters are cleared on state entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package ccc_cfg_pkg holds:
  - the state enum;
  - CCC_CFG_W = 81;
  - field offset constants for the configuration word (FINDIV, FBDIV, OADIV, OBDIV, OCDIV, OAMUX, OBMUX, OCMUX, BYPASS bits), so software and RTL build identical words.
- Sub-module: ccc_lock_sync, the 2-flop synchronizer plus the LOCK_STABLE qualification counter. It outputs a lock_ok level and a lock_drop pulse.

## Test plan
- Reset release, no START → FAB_RST_N=0, SCLK=0, BUSY=0, state stays IDLE for 1000 cycles.
- CFG=81'h1_5555_5555_5555_5555_5555, SCLK_DIV=2 → exactly 81 SCLK pulses of 4 cycles each.
  - The captured SDIN bit stream equals CFG MSB-first.
  - SUPDATE is high for 4 cycles, then BUSY stays high until lock.
- LOCK tied high after update → LOCKED and FAB_RST_N rise exactly LOCK_STABLE+2 cycles after WAIT_LOCK entry.
- LOCK glitches low once at stable count 10, then stays high → counter restarts; release occurs 16 qualified cycles after the glitch.
- LOCK held low → FAULT=1 exactly 1024 cycles after WAIT_LOCK entry, FAB_RST_N stays 0.
  - A later START clears FAULT and restarts SHIFT.
- In RUN, LOCK drops → FAULT=1 and FAB_RST_N=0 within 3 cycles.
- PRESERN pulsed low at bit 40 of SHIFT → outputs zero asynchronously, no SUPDATE issued.
- START during SHIFT → ignored, bit count unchanged.
